npu_mac_lane_core: RTL and testbench

Parametrised NPU compute core. It captures a vector of LANES data/weight pairs on START and accumulates the products serially, one lane per cycle. It then adds a bias, applies optional ReLU and range limiting, and pushes the DW-bit result into an internal show-ahead output FIFO. It sits under `npu_top`, generalising the fixed four-input (DA..DD) datapath to any lane count, width and FIFO depth, with signed mode, ReLU and write-side back-pressure.

---
 rtl/npu_mac_lane_core.sv | 204 ++++++++++++++++++++
 tb/tb_npu_mac_lane_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mac_lane_core.sv
// rtl/npu_mac_lane_core.sv - serial multi-lane MAC core with bias, ReLU, optional clamp and show-ahead output FIFO
//
// Captures LANES data/weight pairs on START, accumulates one lane product per
// cycle, adds the bias, applies ReLU (signed mode) and range limiting, and
// pushes the DW-bit result into a show-ahead FIFO.
// Optional feature macro: NPU_SAT_EN (clamp the result instead of wrapping).
//
// Ports:
//   CLKEXT      clock, all state on rising edge
//   RST_GLO     asynchronous active-high reset
//   START       operation request, sampled only in IDLE
//   MODE[1:0]   bit0 ReLU enable, bit1 signed operands (captured with START)
//   D_IN, W_IN  packed lane data / weights, lane i at [i*DW +: DW]
//   BIAS_IN     bias, captured with START
//   RD_EN       pop FIFO head
//   D_OUT       FIFO head word, 0 while empty
//   FIFO_FULL   FIFO holds FIFO_DEPTH words
//   FIFO_EMPTY  FIFO holds no words
//   BUSY        operation in progress
//   DONE        one-cycle pulse after the result push
module npu_mac_lane_core #(
  parameter int LANES      = 4,
  parameter int DW         = 8,
  parameter int ACC_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLKEXT,
  input  logic                RST_GLO,
  input  logic                START,
  input  logic [1:0]          MODE,
  input  logic [LANES*DW-1:0] D_IN,
  input  logic [LANES*DW-1:0] W_IN,
  input  logic [DW-1:0]       BIAS_IN,
  input  logic                RD_EN,
  output logic [DW-1:0]       D_OUT,
  output logic                FIFO_FULL,
  output logic                FIFO_EMPTY,
  output logic                BUSY,
  output logic                DONE
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_POST  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [LANES*DW-1:0] d_reg, w_reg;
  logic [DW-1:0]       bias_reg;
  logic [1:0]          mode_reg;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [DW-1:0]       result;
  logic                done_r;

  logic [DW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic                full_r, empty_r;
  logic                push, pop;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      S_IDLE:  if (START) state_next = S_MAC;
      S_MAC:   if (cnt == LAST_LANE) state_next = S_POST;
      S_POST:  state_next = S_WRITE;
      S_WRITE: begin
        // A full FIFO still accepts the push when the head is popped on the same edge.
        if (!full_r || RD_EN) begin
          push       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic             sgn;
  logic [DW-1:0]    d_lane, w_lane;
  logic [ACC_W-1:0] d_ext, w_ext, prod;
  logic [ACC_W-1:0] bias_ext, r_sum, r_relu;
  logic [DW-1:0]    post_result;

  assign sgn    = mode_reg[1];
  assign d_lane = d_reg[int'(cnt)*DW +: DW];
  assign w_lane = w_reg[int'(cnt)*DW +: DW];

  // Operands are extended to the accumulator width first; the low ACC_W bits
  // of the product are then correct for both signed and unsigned operands.
  assign d_ext    = {{(ACC_W-DW){sgn & d_lane[DW-1]}}, d_lane};
  assign w_ext    = {{(ACC_W-DW){sgn & w_lane[DW-1]}}, w_lane};
  assign prod     = d_ext * w_ext;

  assign bias_ext = {{(ACC_W-DW){sgn & bias_reg[DW-1]}}, bias_reg};
  assign r_sum    = acc + bias_ext;
  // An unsigned sum can never be negative, so ReLU only bites in signed mode.
  assign r_relu   = (mode_reg[0] && sgn && r_sum[ACC_W-1]) ? '0 : r_sum;

`ifdef NPU_SAT_EN
  logic [ACC_W-DW:0] sign_bits;
  assign sign_bits = r_relu[ACC_W-1:DW-1];

  always_comb begin
    post_result = r_relu[DW-1:0];
    if (sgn) begin
      // Fits in DW signed bits only if everything above bit DW-2 is a pure sign extension.
      if (!((&sign_bits) || !(|sign_bits)))
        post_result = r_relu[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      if (|r_relu[ACC_W-1:DW])
        post_result = {DW{1'b1}};
    end
  end
`else
  logic unused_hi;
  assign post_result = r_relu[DW-1:0];
  assign unused_hi   = ^r_relu[ACC_W-1:DW];
`endif

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      d_reg    <= '0;
      w_reg    <= '0;
      bias_reg <= '0;
      mode_reg <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= push;
      case (state)
        S_IDLE: begin
          if (START) begin
            d_reg    <= D_IN;
            w_reg    <= W_IN;
            bias_reg <= BIAS_IN;
            mode_reg <= MODE;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          if (cnt != LAST_LANE) cnt <= cnt + 1'b1;
        end
        S_POST:  result <= post_result;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO; the extra pointer bit separates full from empty.
  // ---------------------------------------------------------------------------
  assign pop     = RD_EN && !empty_r;
  assign wr_next = wr_ptr + (PTR_W+1)'(push);
  assign rd_next = rd_ptr + (PTR_W+1)'(pop);

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      empty_r <= (wr_next == rd_next);
      full_r  <= (wr_next[PTR_W] != rd_next[PTR_W]) &&
                 (wr_next[PTR_W-1:0] == rd_next[PTR_W-1:0]);
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= result;
  end

  assign D_OUT      = empty_r ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign FIFO_FULL  = full_r;
  assign FIFO_EMPTY = empty_r;
  assign BUSY       = (state != S_IDLE);
  assign DONE       = done_r;

endmodule

// File: tb/tb_npu_mac_lane_core.sv
// tb/tb_npu_mac_lane_core.sv - randomized self-checking bench for npu_mac_lane_core
module tb_npu_mac_lane_core;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 20;
  localparam int DEPTH = 4;

  logic                CLKEXT;
  logic                RST_GLO;
  logic                START;
  logic [1:0]          MODE;
  logic [LANES*DW-1:0] D_IN;
  logic [LANES*DW-1:0] W_IN;
  logic [DW-1:0]       BIAS_IN;
  logic                RD_EN;
  logic [DW-1:0]       D_OUT;
  logic                FIFO_FULL;
  logic                FIFO_EMPTY;
  logic                BUSY;
  logic                DONE;

  npu_mac_lane_core #(
    .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .MODE(MODE),
    .D_IN(D_IN), .W_IN(W_IN), .BIAS_IN(BIAS_IN), .RD_EN(RD_EN),
    .D_OUT(D_OUT), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole vector.
  function automatic logic [DW-1:0] ref_result(input logic [LANES*DW-1:0] d,
                                               input logic [LANES*DW-1:0] w,
                                               input logic [DW-1:0] b,
                                               input logic [1:0] m);
    longint sum = 0;
    longint r;
    longint lo, hi;
    logic [DW-1:0] a, c;
    for (int i = 0; i < LANES; i++) begin
      a = d[i*DW +: DW];
      c = w[i*DW +: DW];
      if (m[1]) sum += longint'($signed(a)) * longint'($signed(c));
      else      sum += longint'(a) * longint'(c);
    end
    r = sum + (m[1] ? longint'($signed(b)) : longint'(b));
    if (m[0] && r < 0) r = 0;
`ifdef NPU_SAT_EN
    lo = m[1] ? -(longint'(1) <<< (DW-1)) : 0;
    hi = m[1] ? (longint'(1) <<< (DW-1)) - 1 : (longint'(1) <<< DW) - 1;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
`else
    lo = 0;
    hi = 0;
`endif
    return r[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  // Full operation into a non-full FIFO; inputs are scrambled after capture.
  task automatic run_op(input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w,
                        input logic [DW-1:0] b, input logic [1:0] m, input string tag);
    int  k;
    bit  seen;
    D_IN = d; W_IN = w; BIAS_IN = b; MODE = m; START = 1'b1;
    tick();
    START   = 1'b0;
    D_IN    = $urandom;
    W_IN    = $urandom;
    BIAS_IN = DW'($urandom);
    MODE    = 2'($urandom);
    check({tag, "_busy"}, 32'(BUSY), 1);
    seen = 0;
    for (k = 1; k <= LANES + 6; k++) begin
      tick();
      if (DONE) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_lat"}, seen ? k : 0, LANES + 2);
    check({tag, "_busy_end"}, 32'(BUSY), 0);
    check({tag, "_nonempty"}, 32'(FIFO_EMPTY), 0);
    exp_q.push_back(ref_result(d, w, b, m));
    tick();
    check({tag, "_done_pulse"}, 32'(DONE), 0);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_empty"}, 32'(FIFO_EMPTY), (exp_q.size() == 0) ? 1 : 0);
    if (exp_q.size() > 0) begin
      check({tag, "_head"}, 32'(D_OUT), 32'(exp_q[0]));
      RD_EN = 1'b1;
      tick();
      RD_EN = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    logic [LANES*DW-1:0] d, w;
    logic [DW-1:0]       b, exp_c, r5;
    logic [1:0]          m;
    int                  k;
    bit                  seen;

    RST_GLO = 1'b1; START = 1'b0; MODE = '0; D_IN = '0; W_IN = '0;
    BIAS_IN = '0; RD_EN = 1'b0;
    tick(); tick();
    check("rst_dout",  32'(D_OUT), 0);
    check("rst_empty", 32'(FIFO_EMPTY), 1);
    check("rst_full",  32'(FIFO_FULL), 0);
    check("rst_busy",  32'(BUSY), 0);
    check("rst_done",  32'(DONE), 0);
    RST_GLO = 1'b0;
    tick();

    // Directed: unsigned sum 0x124
`ifdef NPU_SAT_EN
    exp_c = 8'hFF;
`else
    exp_c = 8'h24;
`endif
    run_op(32'h78563412, 32'h01010101, 8'h10, 2'b00, "dir_u");
    check("dir_u_const", 32'(D_OUT), 32'(exp_c));
    pop_check("dir_u");

    run_op(32'hFEFEFEFE, 32'h03030303, 8'h00, 2'b11, "relu");
    check("relu_const", 32'(D_OUT), 32'h00);
    pop_check("relu");
    run_op(32'hFEFEFEFE, 32'h03030303, 8'h00, 2'b10, "noRelu");
    check("noRelu_const", 32'(D_OUT), 32'hE8);
    pop_check("noRelu");

`ifdef NPU_SAT_EN
    exp_c = 8'h7F;
`else
    exp_c = 8'h04;
`endif
    run_op(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h00, 2'b10, "sat_hi");
    check("sat_hi_const", 32'(D_OUT), 32'(exp_c));
    pop_check("sat_hi");
`ifdef NPU_SAT_EN
    exp_c = 8'h80;
`else
    exp_c = 8'h00;
`endif
    run_op(32'h80808080, 32'h7F7F7F7F, 8'h00, 2'b10, "sat_lo");
    check("sat_lo_const", 32'(D_OUT), 32'(exp_c));
    pop_check("sat_lo");

    for (int i = 0; i < 12; i++) begin
      run_op($urandom, $urandom, DW'($urandom), 2'($urandom), "rnd");
      pop_check("rnd");
    end

    // Back-pressure
    for (int i = 0; i < DEPTH; i++)
      run_op($urandom, $urandom, DW'($urandom), 2'($urandom), "fill");
    check("bp_full", 32'(FIFO_FULL), 1);
    d = $urandom; w = $urandom; b = DW'($urandom); m = 2'($urandom);
    r5 = ref_result(d, w, b, m);
    D_IN = d; W_IN = w; BIAS_IN = b; MODE = m; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (LANES + 5) tick();
    check("bp_busy",  32'(BUSY), 1);
    check("bp_done",  32'(DONE), 0);
    check("bp_full2", 32'(FIFO_FULL), 1);
    check("bp_head1", 32'(D_OUT), 32'(exp_q[0]));
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(r5);
    check("bp_done_after", 32'(DONE), 1);
    check("bp_busy_after", 32'(BUSY), 0);
    check("bp_full_after", 32'(FIFO_FULL), 1);
    check("bp_head2", 32'(D_OUT), 32'(exp_q[0]));
    tick();
    check("bp_done_drop", 32'(DONE), 0);
    for (int i = 0; i < DEPTH; i++) pop_check("bp_drain");
    pop_check("bp_drained");

    // START held high, inputs changed mid-MAC
    d = $urandom; w = $urandom; b = DW'($urandom); m = 2'($urandom);
    D_IN = d; W_IN = w; BIAS_IN = b; MODE = m; START = 1'b1;
    tick();
    tick();
    D_IN = ~d; W_IN = ~w; BIAS_IN = ~b; MODE = ~m;
    seen = 0;
    for (k = 2; k <= LANES + 6; k++) begin
      tick();
      if (DONE) begin
        seen = 1;
        break;
      end
    end
    START = 1'b0;
    check("hold_done_lat", seen ? k : 0, LANES + 2);
    exp_q.push_back(ref_result(d, w, b, m));
    repeat (3) tick();
    check("hold_busy", 32'(BUSY), 0);
    pop_check("hold");
    pop_check("hold_only_one");

    // Reset mid-MAC with two words queued
    run_op($urandom, $urandom, DW'($urandom), 2'($urandom), "pre_rst");
    run_op($urandom, $urandom, DW'($urandom), 2'($urandom), "pre_rst");
    D_IN = $urandom; W_IN = $urandom; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    #2 RST_GLO = 1'b1;
    #1;
    check("mrst_dout",  32'(D_OUT), 0);
    check("mrst_empty", 32'(FIFO_EMPTY), 1);
    check("mrst_full",  32'(FIFO_FULL), 0);
    check("mrst_busy",  32'(BUSY), 0);
    check("mrst_done",  32'(DONE), 0);
    tick();
    RST_GLO = 1'b0;
    exp_q.delete();
    tick();
    run_op($urandom, $urandom, DW'($urandom), 2'($urandom), "post_rst");
    pop_check("post_rst");
    pop_check("post_rst_only");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
